// File: rtl/conv_seq_pkg.sv
// Shared widths and state encoding for the convolution sequencer.
// Imported by conv_seq_ctrl.
package conv_seq_pkg;

    localparam int AW = 12;
    localparam int WW = 10;
    localparam int CW = 4;
    localparam int KW = 4;
    localparam int PW = 10;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        GAP,
        STALL,
        DONE
    } state_t;

endpackage

// File: rtl/conv_seq_ctrl_loop1.sv
// loop1: one nested-loop level, counts 0..max and wraps.
// Chain levels by feeding next into the outer level's en.
module loop1 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] max,
    output logic [W-1:0] cnt,
    output logic         last,
    output logic         next
);

    assign last = (cnt == max);
    assign next = en & last;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: walks output windows and taps, emitting source
// and weight addresses one tap per cycle for the convolution core.
module conv_seq_ctrl
    import conv_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          s_init,
    input  logic          out_busy,
    input  logic [CW-1:0] id,
    input  logic [AW-1:0] is,
    input  logic [PW-1:0] iw,
    input  logic [KW-1:0] kw,
    input  logic [KW-1:0] kh,
    input  logic [PW-1:0] ow,
    input  logic [PW-1:0] oh,
    output logic          exec,
    output logic          k_init,
    output logic          k_fin,
    output logic          s_fin,
    output logic          busy,
    output logic [AW-1:0] ia,
    output logic [WW-1:0] wa
);

    state_t state;

    logic [CW-1:0] id_q;
    logic [AW-1:0] is_q;
    logic [PW-1:0] iw_q;
    logic [KW-1:0] kw_q;
    logic [KW-1:0] kh_q;
    logic [PW-1:0] ow_q;
    logic [PW-1:0] oh_q;

    logic [CW-1:0] c_id;
    logic [AW-1:0] c_is;
    logic [PW-1:0] c_iw;
    logic [KW-1:0] c_kw;
    logic [KW-1:0] c_kh;
    logic [PW-1:0] c_ow;
    logic [PW-1:0] c_oh;

    logic          idle;
    logic          step;
    logic          wend;
    logic          win_end_q;
    logic          lay_end_q;

    logic [KW-1:0] kx_cnt;
    logic [KW-1:0] ky_cnt;
    logic [CW-1:0] ic_cnt;
    logic [PW-1:0] ox_cnt;
    logic [PW-1:0] oy_cnt;
    logic          kx_last, ky_last, ic_last, ox_last, oy_last;
    logic          kx_nx, ky_nx, ic_nx, ox_nx, oy_nx;
    logic          unused_cnt;

    logic [AW-1:0] rbase;
    logic [AW-1:0] cbase;
    logic [AW-1:0] obase;
    logic [WW-1:0] wcnt;
    logic [AW-1:0] addr;

    // The first tap is issued while still in IDLE, so it must see the ports.
    assign idle = (state == IDLE);
    assign c_id = idle ? id : id_q;
    assign c_is = idle ? is : is_q;
    assign c_iw = idle ? iw : iw_q;
    assign c_kw = idle ? kw : kw_q;
    assign c_kh = idle ? kh : kh_q;
    assign c_ow = idle ? ow : ow_q;
    assign c_oh = idle ? oh : oh_q;

    assign step = (idle & s_init)
                | ((state == RUN) & ~win_end_q)
                | (((state == GAP) & ~lay_end_q) | (state == STALL))
                  & ~out_busy;

    assign wend = kx_last & ky_last & ic_last;
    assign unused_cnt = ^{ky_cnt, ic_cnt, oy_cnt};

    loop1 #(.W(KW)) u_kx (
        .clk(clk), .rst(rst), .en(step), .max(c_kw),
        .cnt(kx_cnt), .last(kx_last), .next(kx_nx)
    );

    loop1 #(.W(KW)) u_ky (
        .clk(clk), .rst(rst), .en(kx_nx), .max(c_kh),
        .cnt(ky_cnt), .last(ky_last), .next(ky_nx)
    );

    loop1 #(.W(CW)) u_ic (
        .clk(clk), .rst(rst), .en(ky_nx), .max(c_id),
        .cnt(ic_cnt), .last(ic_last), .next(ic_nx)
    );

    loop1 #(.W(PW)) u_ox (
        .clk(clk), .rst(rst), .en(ic_nx), .max(c_ow),
        .cnt(ox_cnt), .last(ox_last), .next(ox_nx)
    );

    loop1 #(.W(PW)) u_oy (
        .clk(clk), .rst(rst), .en(ox_nx), .max(c_oh),
        .cnt(oy_cnt), .last(oy_last), .next(oy_nx)
    );

    assign addr = obase + AW'(ox_cnt) + cbase + rbase + AW'(kx_cnt);

    // Base registers track the tap about to be issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rbase <= '0;
            cbase <= '0;
            obase <= '0;
            wcnt  <= '0;
        end else if (step) begin
            wcnt <= wend ? '0 : wcnt + WW'(1);
            if (kx_nx) rbase <= ky_nx ? '0 : rbase + AW'(c_iw);
            if (ky_nx) cbase <= ic_nx ? '0 : cbase + c_is;
            if (ox_nx) obase <= oy_nx ? '0 : obase + AW'(c_iw);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            exec      <= 1'b0;
            k_init    <= 1'b0;
            k_fin     <= 1'b0;
            s_fin     <= 1'b0;
            busy      <= 1'b0;
            ia        <= '0;
            wa        <= '0;
            win_end_q <= 1'b0;
            lay_end_q <= 1'b0;
            id_q      <= '0;
            is_q      <= '0;
            iw_q      <= '0;
            kw_q      <= '0;
            kh_q      <= '0;
            ow_q      <= '0;
            oh_q      <= '0;
        end else begin
            exec   <= step;
            k_init <= step & (wcnt == '0);
            ia     <= step ? addr : '0;
            wa     <= step ? wcnt : '0;
            k_fin  <= 1'b0;
            s_fin  <= 1'b0;
            if (step) begin
                win_end_q <= wend;
                lay_end_q <= wend & ox_last & oy_last;
            end
            unique case (state)
                IDLE: begin
                    if (s_init) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        id_q  <= id;
                        is_q  <= is;
                        iw_q  <= iw;
                        kw_q  <= kw;
                        kh_q  <= kh;
                        ow_q  <= ow;
                        oh_q  <= oh;
                    end
                end
                RUN: begin
                    if (win_end_q) begin
                        state <= GAP;
                        k_fin <= 1'b1;
                    end
                end
                GAP: begin
                    if (lay_end_q) begin
                        state <= DONE;
                        s_fin <= 1'b1;
                    end else if (out_busy) begin
                        state <= STALL;
                    end else begin
                        state <= RUN;
                    end
                end
                STALL: begin
                    if (!out_busy) state <= RUN;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
